// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Groups the fetch port, data port and backing-memory port of the shared
// memory arbiter into one bundle.
//   start_i                      enable; no new grants while low
//   if_req_i/if_addr_i           instruction read request and byte address
//   if_rdata_o/if_ready_o        fetched word and one-cycle completion pulse
//   d_req_i/d_we_i/d_be_i        data request, store enable, byte enables
//   d_addr_i/d_wdata_i           data byte address and store data
//   d_rdata_o/d_ready_o          load data and one-cycle completion pulse
//   err_o                        pulse alongside a ready when the access timed out
//   mem_req_o/mem_we_o/mem_be_o  backing-memory request, write enable, byte enables
//   mem_addr_o/mem_wdata_o       backing-memory address and write data
//   mem_rdata_i/mem_ack_i        backing-memory read data and completion
// Modports: slave = arbiter view, master = environment (pipeline + memory) view.
interface mem_port_arbiter_if;
   logic        start_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_ready_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [3:0]  d_be_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [31:0] d_rdata_o;
   logic        d_ready_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;

   modport slave (
      input  start_i, if_req_i, if_addr_i, d_req_i, d_we_i, d_be_i, d_addr_i,
             d_wdata_i, mem_rdata_i, mem_ack_i,
      output if_rdata_o, if_ready_o, d_rdata_o, d_ready_o, err_o,
             mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output start_i, if_req_i, if_addr_i, d_req_i, d_we_i, d_be_i, d_addr_i,
             d_wdata_i, mem_rdata_i, mem_ack_i,
      input  if_rdata_o, if_ready_o, d_rdata_o, d_ready_o, err_o,
             mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch and load/store.
// Each access walks IDLE -> I_BUSY/D_BUSY -> RESP -> IDLE, so back-to-back
// accesses take at least three cycles. Data normally wins a tie, but after
// MAX_D_BURST consecutive data grants with a fetch waiting the fetch wins.
// A watchdog aborts an access that sees no ack for TIMEOUT cycles and
// reports it with err_o alongside the ready pulse.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave (fetch, data and memory ports)
// All interface outputs are registered.
module mem_port_arbiter #(
   parameter int MAX_D_BURST = 4,
   parameter int TIMEOUT     = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   mem_port_arbiter_if.slave     bus
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

   localparam logic [3:0] L_BURST_MAX = 4'(MAX_D_BURST);
   localparam logic [7:0] L_WD_LAST   = 8'(TIMEOUT - 1);

   state_t      r_state,      w_state_next;
   logic [3:0]  r_burst_cnt,  w_burst_cnt_next;
   logic [7:0]  r_wd_cnt,     w_wd_cnt_next;
   logic        r_if_ready,   w_if_ready_next;
   logic [31:0] r_if_rdata,   w_if_rdata_next;
   logic        r_d_ready,    w_d_ready_next;
   logic [31:0] r_d_rdata,    w_d_rdata_next;
   logic        r_err,        w_err_next;
   logic        r_mem_req,    w_mem_req_next;
   logic        r_mem_we,     w_mem_we_next;
   logic [3:0]  r_mem_be,     w_mem_be_next;
   logic [31:0] r_mem_addr,   w_mem_addr_next;
   logic [31:0] r_mem_wdata,  w_mem_wdata_next;

   logic w_burst_full;
   logic w_grant_d;
   logic w_grant_i;
   logic w_wd_expired;
   logic w_finish;

   always_comb begin
      w_state_next     = r_state;
      w_burst_cnt_next = r_burst_cnt;
      w_wd_cnt_next    = r_wd_cnt;
      w_if_ready_next  = 1'b0;
      w_if_rdata_next  = r_if_rdata;
      w_d_ready_next   = 1'b0;
      w_d_rdata_next   = r_d_rdata;
      w_err_next       = 1'b0;
      w_mem_req_next   = r_mem_req;
      w_mem_we_next    = r_mem_we;
      w_mem_be_next    = r_mem_be;
      w_mem_addr_next  = r_mem_addr;
      w_mem_wdata_next = r_mem_wdata;

      // Fetch only overrides data once the burst budget is spent.
      w_burst_full = (r_burst_cnt == L_BURST_MAX);
      w_grant_d    = bus.start_i && bus.d_req_i && !(bus.if_req_i && w_burst_full);
      w_grant_i    = bus.start_i && bus.if_req_i && !w_grant_d;
      w_wd_expired = (r_wd_cnt == L_WD_LAST);
      // An ack in the last watchdog cycle still counts as a normal completion.
      w_finish     = bus.mem_ack_i || w_wd_expired;

      case (r_state)
         IDLE: begin
            if (!bus.if_req_i || w_grant_i) begin
               w_burst_cnt_next = 4'd0;
            end else if (w_grant_d && !w_burst_full) begin
               w_burst_cnt_next = r_burst_cnt + 4'd1;
            end

            if (w_grant_d) begin
               w_mem_req_next   = 1'b1;
               w_mem_we_next    = bus.d_we_i;
               w_mem_be_next    = bus.d_be_i;
               w_mem_addr_next  = bus.d_addr_i;
               w_mem_wdata_next = bus.d_wdata_i;
               w_state_next     = D_BUSY;
            end else if (w_grant_i) begin
               w_mem_req_next   = 1'b1;
               w_mem_we_next    = 1'b0;
               w_mem_be_next    = 4'hF;
               w_mem_addr_next  = bus.if_addr_i;
               w_mem_wdata_next = 32'd0;
               w_state_next     = I_BUSY;
            end
         end

         I_BUSY, D_BUSY: begin
            w_wd_cnt_next = r_wd_cnt + 8'd1;
            if (w_finish) begin
               w_wd_cnt_next  = 8'd0;
               w_mem_req_next = 1'b0;
               w_err_next     = !bus.mem_ack_i;
               w_state_next   = RESP;
               // A timed-out access returns zero rather than stale bus data.
               if (r_state == I_BUSY) begin
                  w_if_ready_next = 1'b1;
                  w_if_rdata_next = bus.mem_ack_i ? bus.mem_rdata_i : 32'd0;
               end else begin
                  w_d_ready_next  = 1'b1;
                  w_d_rdata_next  = bus.mem_ack_i ? bus.mem_rdata_i : 32'd0;
               end
            end
         end

         // Requests are ignored here: the winner is still dropping its request.
         RESP: begin
            w_state_next = IDLE;
         end

         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= IDLE;
         r_burst_cnt <= 4'd0;
         r_wd_cnt    <= 8'd0;
         r_if_ready  <= 1'b0;
         r_if_rdata  <= 32'd0;
         r_d_ready   <= 1'b0;
         r_d_rdata   <= 32'd0;
         r_err       <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= 4'd0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
      end else begin
         r_state     <= w_state_next;
         r_burst_cnt <= w_burst_cnt_next;
         r_wd_cnt    <= w_wd_cnt_next;
         r_if_ready  <= w_if_ready_next;
         r_if_rdata  <= w_if_rdata_next;
         r_d_ready   <= w_d_ready_next;
         r_d_rdata   <= w_d_rdata_next;
         r_err       <= w_err_next;
         r_mem_req   <= w_mem_req_next;
         r_mem_we    <= w_mem_we_next;
         r_mem_be    <= w_mem_be_next;
         r_mem_addr  <= w_mem_addr_next;
         r_mem_wdata <= w_mem_wdata_next;
      end
   end

   assign bus.if_ready_o  = r_if_ready;
   assign bus.if_rdata_o  = r_if_rdata;
   assign bus.d_ready_o   = r_d_ready;
   assign bus.d_rdata_o   = r_d_rdata;
   assign bus.err_o       = r_err;
   assign bus.mem_req_o   = r_mem_req;
   assign bus.mem_we_o    = r_mem_we;
   assign bus.mem_be_o    = r_mem_be;
   assign bus.mem_addr_o  = r_mem_addr;
   assign bus.mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (MAX_D_BURST = 4, TIMEOUT = 16).
// Single-cycle behaviour comes from a table of {inputs, expected outputs};
// fairness, watchdog, async reset and start gating are hand-written sequences.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic auto_ack = 1'b0;
   logic man_ack = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.MAX_D_BURST(4), .TIMEOUT(16)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   // Memory model: either acks in the same cycle as the request or follows man_ack.
   assign bus.mem_ack_i = auto_ack ? bus.mem_req_o : man_ack;

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [3:0]  d_be;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        ack;
      logic [31:0] rdata;
      logic        e_req;
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_if_rdy;
      logic [31:0] e_if_rdata;
      logic        e_d_rdy;
      logic [31:0] e_d_rdata;
      logic        e_err;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_req(input logic st, input logic ir, input logic [31:0] ia,
                          input logic dr, input logic dw, input logic [3:0] db,
                          input logic [31:0] da, input logic [31:0] dwd);
      bus.start_i   = st;
      bus.if_req_i  = ir;
      bus.if_addr_i = ia;
      bus.d_req_i   = dr;
      bus.d_we_i    = dw;
      bus.d_be_i    = db;
      bus.d_addr_i  = da;
      bus.d_wdata_i = dwd;
   endtask

   task automatic wait_grant(output logic [31:0] addr, output bit ok);
      ok   = 1'b0;
      addr = 32'd0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.mem_req_o) begin
            addr = bus.mem_addr_o;
            ok   = 1'b1;
            break;
         end
      end
      $display("grant: addr=%h we=%b ok=%0d", addr, bus.mem_we_o, ok);
   endtask

   initial begin
      logic [31:0] g_addr;
      bit          g_ok;
      bit          fair_is_d[10];
      int          req_cycles;
      bit          got_rdy;

      // Fetch at 0x10, tie with store at 0x04, fetch at 0x20, byte-masked load at 0x44.
      vecs[0]  = '{1,1,32'h10,0,0,4'h0,32'h0,32'h0,0,32'h0,         1,0,4'hF,32'h10,32'h0,       0,32'h0,       0,32'h0,       0};
      vecs[1]  = '{1,1,32'h10,0,0,4'h0,32'h0,32'h0,1,32'h00500093,  0,0,4'hF,32'h10,32'h0,       1,32'h00500093,0,32'h0,       0};
      vecs[2]  = '{1,0,32'h0, 0,0,4'h0,32'h0,32'h0,0,32'h0,         0,0,4'hF,32'h10,32'h0,       0,32'h00500093,0,32'h0,       0};
      vecs[3]  = '{1,1,32'h20,1,1,4'hF,32'h4,32'hDEADBEEF,0,32'h0,  1,1,4'hF,32'h4,32'hDEADBEEF, 0,32'h00500093,0,32'h0,       0};
      vecs[4]  = '{1,1,32'h20,1,1,4'hF,32'h4,32'hDEADBEEF,1,32'hCAFEF00D, 0,1,4'hF,32'h4,32'hDEADBEEF, 0,32'h00500093,1,32'hCAFEF00D,0};
      vecs[5]  = '{1,1,32'h20,0,0,4'h0,32'h0,32'h0,0,32'h0,         0,1,4'hF,32'h4,32'hDEADBEEF, 0,32'h00500093,0,32'hCAFEF00D,0};
      vecs[6]  = '{1,1,32'h20,0,0,4'h0,32'h0,32'h0,0,32'h0,         1,0,4'hF,32'h20,32'h0,       0,32'h00500093,0,32'hCAFEF00D,0};
      vecs[7]  = '{1,1,32'h20,0,0,4'h0,32'h0,32'h0,1,32'h00000013,  0,0,4'hF,32'h20,32'h0,       1,32'h00000013,0,32'hCAFEF00D,0};
      vecs[8]  = '{0,0,32'h0, 0,0,4'h0,32'h0,32'h0,0,32'h0,         0,0,4'hF,32'h20,32'h0,       0,32'h00000013,0,32'hCAFEF00D,0};
      vecs[9]  = '{1,0,32'h0, 1,0,4'h3,32'h44,32'h11,0,32'h0,       1,0,4'h3,32'h44,32'h11,      0,32'h00000013,0,32'hCAFEF00D,0};
      vecs[10] = '{1,0,32'h0, 1,0,4'h3,32'h44,32'h11,1,32'h0000BEEF,0,0,4'h3,32'h44,32'h11,      0,32'h00000013,1,32'h0000BEEF,0};
      vecs[11] = '{1,0,32'h0, 0,0,4'h0,32'h0,32'h0,0,32'h0,         0,0,4'h3,32'h44,32'h11,      0,32'h00000013,0,32'h0000BEEF,0};

      set_req(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      bus.mem_rdata_i = 32'h0;

      // Reset state.
      @(posedge clk); #1;
      check("rst_mem_req", bus.mem_req_o, 0);
      check("rst_if_ready", bus.if_ready_o, 0);
      check("rst_d_ready", bus.d_ready_o, 0);
      check("rst_err", bus.err_o, 0);
      check("rst_mem_addr", bus.mem_addr_o, 0);
      check("rst_if_rdata", bus.if_rdata_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Table-driven cycles.
      for (int v = 0; v < 12; v++) begin
         set_req(vecs[v].start, vecs[v].if_req, vecs[v].if_addr, vecs[v].d_req,
                 vecs[v].d_we, vecs[v].d_be, vecs[v].d_addr, vecs[v].d_wdata);
         man_ack         = vecs[v].ack;
         bus.mem_rdata_i = vecs[v].rdata;
         @(posedge clk); #1;
         $display("vec %0d: req=%b we=%b be=%h addr=%h ifr=%b ifd=%h dr=%b dd=%h err=%b", v,
                  bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o,
                  bus.if_ready_o, bus.if_rdata_o, bus.d_ready_o, bus.d_rdata_o, bus.err_o);
         check($sformatf("v%0d_mem_req", v),   bus.mem_req_o,   vecs[v].e_req);
         check($sformatf("v%0d_mem_we", v),    bus.mem_we_o,    vecs[v].e_we);
         check($sformatf("v%0d_mem_be", v),    bus.mem_be_o,    vecs[v].e_be);
         check($sformatf("v%0d_mem_addr", v),  bus.mem_addr_o,  vecs[v].e_addr);
         check($sformatf("v%0d_mem_wdata", v), bus.mem_wdata_o, vecs[v].e_wdata);
         check($sformatf("v%0d_if_ready", v),  bus.if_ready_o,  vecs[v].e_if_rdy);
         check($sformatf("v%0d_if_rdata", v),  bus.if_rdata_o,  vecs[v].e_if_rdata);
         check($sformatf("v%0d_d_ready", v),   bus.d_ready_o,   vecs[v].e_d_rdy);
         check($sformatf("v%0d_d_rdata", v),   bus.d_rdata_o,   vecs[v].e_d_rdata);
         check($sformatf("v%0d_err", v),       bus.err_o,       vecs[v].e_err);
      end
      man_ack = 1'b0;

      // Fairness: both requesters always asserting -> D D D D I D D D D I.
      fair_is_d = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      auto_ack        = 1'b1;
      bus.mem_rdata_i = 32'hA5A5A5A5;
      set_req(1, 1, 32'h100, 1, 0, 4'hF, 32'h200, 32'h0);
      for (int g = 0; g < 10; g++) begin
         wait_grant(g_addr, g_ok);
         check($sformatf("fair_ok%0d", g), g_ok, 1);
         check($sformatf("fair_grant%0d", g), g_addr, fair_is_d[g] ? 32'h200 : 32'h100);
      end
      set_req(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      auto_ack = 1'b0;

      // Watchdog: load at 0x08 is never acked.
      set_req(1, 0, 32'h0, 1, 0, 4'hF, 32'h8, 32'h0);
      wait_grant(g_addr, g_ok);
      check("to_grant_addr", g_addr, 32'h8);
      req_cycles = g_ok ? 1 : 0;
      got_rdy    = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (bus.d_ready_o) begin
            got_rdy = 1'b1;
            break;
         end
         if (bus.mem_req_o) req_cycles++;
      end
      $display("timeout: req_cycles=%0d ready=%0d err=%b rdata=%h", req_cycles, got_rdy, bus.err_o, bus.d_rdata_o);
      check("to_ready_seen", got_rdy, 1);
      check("to_req_cycles", req_cycles, 16);
      check("to_err", bus.err_o, 1);
      check("to_d_rdata", bus.d_rdata_o, 32'h0);
      check("to_mem_req", bus.mem_req_o, 0);
      check("to_if_ready", bus.if_ready_o, 0);
      set_req(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      @(posedge clk); #1;
      check("to_err_pulse", bus.err_o, 0);
      check("to_ready_pulse", bus.d_ready_o, 0);
      @(posedge clk); #1;
      man_ack         = 1'b1;
      bus.mem_rdata_i = 32'h55;
      @(posedge clk); #1;
      man_ack = 1'b0;
      check("late_ack_ready", bus.d_ready_o, 0);
      check("late_ack_rdata", bus.d_rdata_o, 32'h0);
      check("late_ack_err", bus.err_o, 0);
      check("late_ack_req", bus.mem_req_o, 0);

      // Build burst_cnt up to 4, then reset in the middle of the 4th data access.
      auto_ack        = 1'b1;
      bus.mem_rdata_i = 32'h0;
      set_req(1, 1, 32'h100, 1, 1, 4'hF, 32'h300, 32'h77);
      for (int g = 0; g < 3; g++) begin
         wait_grant(g_addr, g_ok);
         check($sformatf("pre_rst_grant%0d", g), g_addr, 32'h300);
      end
      @(posedge clk); #1;
      auto_ack = 1'b0;
      wait_grant(g_addr, g_ok);
      check("pre_rst_grant3", g_addr, 32'h300);
      #3;
      rst_n = 1'b0;
      #1;
      $display("async reset: req=%b addr=%h dr=%b", bus.mem_req_o, bus.mem_addr_o, bus.d_ready_o);
      check("arst_mem_req", bus.mem_req_o, 0);
      check("arst_mem_we", bus.mem_we_o, 0);
      check("arst_mem_addr", bus.mem_addr_o, 32'h0);
      check("arst_d_ready", bus.d_ready_o, 0);
      check("arst_if_rdata", bus.if_rdata_o, 32'h0);
      @(posedge clk); #1;
      check("arst_hold_req", bus.mem_req_o, 0);
      rst_n = 1'b1;

      // start_i low with both requests high: no grant for 5 cycles.
      auto_ack = 1'b1;
      set_req(0, 1, 32'h100, 1, 1, 4'hF, 32'h300, 32'h77);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("nostart_req%0d", c), bus.mem_req_o, 0);
         check($sformatf("nostart_rdy%0d", c), bus.d_ready_o, 0);
      end
      bus.start_i = 1'b1;
      @(posedge clk); #1;
      $display("start: req=%b addr=%h we=%b", bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o);
      check("start_grant_req", bus.mem_req_o, 1);
      check("start_grant_addr", bus.mem_addr_o, 32'h300);
      check("start_grant_we", bus.mem_we_o, 1);
      // A cleared burst count allows three more data grants before the fetch.
      for (int g = 0; g < 4; g++) begin
         wait_grant(g_addr, g_ok);
         check($sformatf("post_rst_grant%0d", g), g_addr, (g < 3) ? 32'h300 : 32'h100);
      end
      set_req(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Both ready pulses must never coincide.
   always @(negedge clk) begin
      if (rst_n && bus.if_ready_o && bus.d_ready_o) begin
         n_checks++;
         n_errors++;
         $display("FAIL dual_ready: got if=%b d=%b expected not both", bus.if_ready_o, bus.d_ready_o);
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RISC-V pipeline.
- Arbitrates requests and sequences each access through an FSM.
- Returns data and a one-cycle ready pulse to the winning requester; the hazard unit uses this pulse to stall the pipeline.
- A fairness counter prevents data-side starvation of fetch, and a watchdog terminates hung accesses with an error.

Parameters:
- MAX_D_BURST, 4: maximum consecutive data grants while an instruction request waits; range 1..15.
- TIMEOUT, 16: cycles in a BUSY state without mem_ack_i before the access is aborted; range 2..255.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  enable; when low, no new grants are issued.
- if_req_i  in  1  instruction read request; held high until if_ready_o.
- if_addr_i  in  32  instruction byte address.
- if_rdata_o  out  32  fetched instruction; valid while if_ready_o is high.
- if_ready_o  out  1  one-cycle completion pulse for the fetch.
- d_req_i  in  1  data request; held high until d_ready_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_be_i  in  4  byte enables.
- d_addr_i  in  32  data byte address.
- d_wdata_i  in  32  store data.
- d_rdata_o  out  32  load data; valid while d_ready_o is high.
- d_ready_o  out  1  one-cycle completion pulse for the data access.
- err_o  out  1  one-cycle pulse coincident with a ready pulse when the access timed out.
- mem_req_o  out  1  backing-memory request.
- mem_we_o  out  1  write enable to memory.
- mem_be_o  out  4  byte enables to memory.
- mem_addr_o  out  32  address to memory.
- mem_wdata_o  out  32  write data to memory.
- mem_rdata_i  in  32  read data from memory.
- mem_ack_i  in  1  access complete; mem_rdata_i is valid in the same cycle.

Behaviour:
- Reset (rst_i = 0, asynchronous): state goes to IDLE. All outputs go to 0, including mem_req_o, which drops immediately. burst_cnt = 0, wd_cnt = 0. Any access in flight is abandoned and no ready pulse is issued for it.
- States: IDLE, I_BUSY, D_BUSY, RESP. All outputs are registered.
- IDLE:
  - No grant while start_i = 0 or neither request is high.
  - If both requests are high: data wins, unless burst_cnt == MAX_D_BURST, in which case instruction wins.
  - If only one request is high, that requester wins.
  - On a grant, the winner's addr/we/be/wdata are latched into mem_*_o, mem_req_o = 1, and the FSM enters I_BUSY or D_BUSY. mem_we_o = 0 and mem_be_o = 4'hF for fetches.
- burst_cnt:
  - Increments on a data grant while if_req_i = 1, saturating at MAX_D_BURST.
  - Clears on every instruction grant, and on any IDLE cycle where if_req_i = 0.
- I_BUSY / D_BUSY:
  - mem_* outputs are held stable. wd_cnt increments each cycle.
  - When mem_ack_i = 1: mem_rdata_i is captured into the winner's rdata_o, the winner's ready_o = 1 next cycle, mem_req_o = 0, and the FSM enters RESP.
  - When wd_cnt reaches TIMEOUT-1 without ack: rdata_o = 0, ready_o = 1 and err_o = 1 next cycle, mem_req_o = 0, and the FSM enters RESP.
  - wd_cnt clears on leaving the BUSY state.
  - A late ack arriving in RESP or IDLE is ignored.
- RESP: exactly one cycle. ready_o and err_o are high for this cycle only, and rdata_o holds its value. Requests are not sampled, because the requester is still dropping its request. Next state is IDLE.
- Latency: a request seen at edge N gets mem_req_o at N+1. With a same-cycle ack, ready_o is high at N+2. Back-to-back accesses therefore take a minimum of 3 cycles each.
- start_i falling mid-access: the current access completes normally; no new grant is issued afterwards.
- d_ready_o and if_ready_o are never high in the same cycle.
- rdata_o holds its last value outside ready cycles.

Test Plan:
- Single fetch: start_i = 1, if_req_i = 1, if_addr_i = 0x10, memory acks immediately with 0x00500093 → mem_addr_o = 0x10 for one cycle; if_rdata_o = 0x00500093 with if_ready_o high exactly 2 cycles after the request edge.
- Simultaneous requests: if_req_i = d_req_i = 1, d_we_i = 1, d_addr_i = 0x04, d_wdata_i = 0xDEADBEEF, d_be_i = 4'hF → the store is granted first (mem_we_o = 1, wdata = 0xDEADBEEF); d_ready_o pulses, then the fetch is granted.
- Fairness: d_req_i re-asserted continuously, if_req_i held high, MAX_D_BURST = 4 → exactly 4 data grants, then the instruction grant, then burst_cnt = 0.
- Timeout: grant a load at 0x08 and never ack, TIMEOUT = 16 → mem_req_o high for 16 cycles; d_ready_o = err_o = 1 with d_rdata_o = 0; an ack 3 cycles later is ignored.
- Async reset mid-access: assert rst_i = 0 between edges during D_BUSY → mem_req_o and all outputs go to 0 immediately, with no d_ready_o; after release, the FSM is in IDLE and burst_cnt = 0.
- start_i = 0 with both requests high for 5 cycles → mem_req_o stays 0; raising start_i yields a data grant on the next edge.
